// File: rtl/dbg_arb_pkg.sv
// rtl/dbg_arb_pkg.sv - shared types and constants for the debug register file arbiter
// Contents: arbiter FSM state enum, lock-region geometry, latched transaction struct.
package dbg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Each lock bit covers a 16-word region; 8 regions span the 128-word file.
    localparam int REGION_SHIFT = 4;
    localparam int N_REGIONS    = 8;

    localparam int TXN_AW = 7;
    localparam int TXN_DW = 32;

    typedef struct packed {
        logic              we;
        logic [TXN_AW-1:0] addr;
        logic [TXN_DW-1:0] wdata;
    } txn_t;

endpackage

// File: rtl/dbg_regfile_arbiter_rr_pick.sv
// rtl/dbg_regfile_arbiter_rr_pick.sv - combinational round-robin winner selection
// Ports: req (request vector), ptr (search start index),
//        gnt (one-hot winner, zero when no request), idx (winner index).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   k;

    // Scan upward from ptr, wrapping once; the first set bit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/dbg_regfile_arbiter.sv
// rtl/dbg_regfile_arbiter.sv - round-robin arbiter for the 128x32 debug register file
// Ports: clk_i/rst_i (sync active-high reset); requester side req_i, we_i, addr_i,
//        wdata_i (packed per requester), gnt_o, rvalid_o, err_o, rdata_o;
//        reglk_ctrl_i region write locks; memory side mem_req_o, mem_we_o,
//        mem_addr_o, mem_wdata_o, mem_rdata_i, mem_ready_i.
module dbg_regfile_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 7,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        we_i,
    input  logic [N_REQ*AW-1:0]     addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [7:0]              reglk_ctrl_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        rvalid_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int REG_W = $clog2(N_REGIONS);

    arb_state_e       state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q;
    txn_t             txn_q;

    logic [N_REQ-1:0]      pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  we_sel;
    logic [AW-1:0]         addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic                  lock_hit;
    logic [N_REQ-1:0]      win_onehot;
    logic [IDX_W-1:0]      rr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req_i),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign we_sel    = we_i[pick_idx];
    assign addr_sel  = addr_i[pick_idx*AW +: AW];
    assign wdata_sel = wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];

    // Lock is judged at grant time only; later lock changes never abort an accepted write.
    assign lock_hit = we_sel && reglk_ctrl_i[addr_sel[REGION_SHIFT +: REG_W]];

    assign win_onehot = N_REQ'(1) << win_q;
    assign rr_next    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    // Grant is combinational so the requester sees acceptance in its request cycle.
    assign gnt_o = (state_q == IDLE && !rst_i) ? pick_gnt : '0;

    // Memory-side fields are only driven while the strobe is up.
    assign mem_we_o    = mem_req_o & txn_q.we;
    assign mem_addr_o  = mem_req_o ? txn_q.addr  : '0;
    assign mem_wdata_o = mem_req_o ? txn_q.wdata : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            txn_q     <= '0;
            mem_req_o <= 1'b0;
            rvalid_o  <= '0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
        end else begin
            rvalid_o <= '0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (|req_i) begin
                        win_q <= pick_idx;
                        txn_q <= '{we: we_sel, addr: addr_sel, wdata: wdata_sel};
                        if (lock_hit) begin
                            state_q  <= RESP;
                            rvalid_o <= pick_gnt;
                            err_o    <= 1'b1;
                        end else begin
                            state_q   <= ACCESS;
                            mem_req_o <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // Ready takes priority over an expiring timeout in the same cycle.
                    if (mem_ready_i) begin
                        state_q   <= RESP;
                        mem_req_o <= 1'b0;
                        rvalid_o  <= win_onehot;
                        rdata_o   <= txn_q.we ? '0 : mem_rdata_i;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q   <= RESP;
                        mem_req_o <= 1'b0;
                        rvalid_o  <= win_onehot;
                        err_o     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr_q <= rr_next;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_regfile_arbiter.sv
// tb/tb_dbg_regfile_arbiter.sv - directed self-checking bench for dbg_regfile_arbiter
module tb_dbg_regfile_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AWD = 7;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N-1:0]    we_i;
    logic [N*AWD-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [7:0]      reglk_ctrl_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rvalid_o;
    logic            err_o;
    logic [DW-1:0]   rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [AWD-1:0]  mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW-1:0]   mem_rdata_i;
    logic            mem_ready_i;

    int checks = 0;
    int errors = 0;

    dbg_regfile_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .AW         (AWD),
        .TIMEOUT    (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .reglk_ctrl_i (reglk_ctrl_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        reglk_ctrl_i = '0; mem_rdata_i = '0; mem_ready_i = 1'b0;
        tick(); tick();
        req_i = 4'b1111;
        #1;
        checks++;
        if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt_o); end
        req_i = '0;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got rv=%b err=%b rd=%h mreq=%b", rvalid_o, err_o, rdata_o, mem_req_o);
        end
    endtask

    task automatic test_single_read;
        req_i = 4'b0001; we_i = '0; addr_i[0*AWD +: AWD] = 7'd3;
        mem_ready_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (gnt_o !== 4'b0001) begin errors++; $display("FAIL read_gnt got %b exp 0001", gnt_o); end
        tick();
        req_i = '0;
        #1;
        checks++;
        if (gnt_o !== 4'b0000) begin errors++; $display("FAIL read_gnt_pulse got %b exp 0000", gnt_o); end
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 7'd3}) begin
            errors++; $display("FAIL read_mem got req=%b we=%b addr=%0d exp 1 0 3", mem_req_o, mem_we_o, mem_addr_o);
        end
        tick();
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {4'b0001, 1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL read_resp got rv=%b err=%b rd=%h exp 0001 0 deadbeef", rvalid_o, err_o, rdata_o);
        end
        tick();
        checks++;
        if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL read_rvalid_pulse got %b exp 0000", rvalid_o); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp;
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        req_i = 4'b1111; we_i = '0; mem_ready_i = 1'b1;
        for (int k = 0; k < N; k++) addr_i[k*AWD +: AWD] = AWD'(k + 40);
        for (int t = 0; t < 8; t++) begin
            exp = 4'b0001 << (t % 4);
            mem_rdata_i = 32'h1000 + t;
            #1;
            checks++;
            if (gnt_o !== exp) begin errors++; $display("FAIL rr_gnt_%0d got %b exp %b", t, gnt_o, exp); end
            tick();
            tick();
            checks++;
            if ({rvalid_o, rdata_o} !== {exp, 32'h1000 + t}) begin
                errors++; $display("FAIL rr_resp_%0d got rv=%b rd=%h exp %b %h", t, rvalid_o, rdata_o, exp, 32'h1000 + t);
            end
            tick();
        end
        req_i = '0;
    endtask

    task automatic test_locked_write;
        reglk_ctrl_i = 8'h01;
        req_i = 4'b0100; we_i = 4'b0100;
        addr_i[2*AWD +: AWD] = 7'd5; wdata_i[2*DW +: DW] = 32'hA5A5_5A5A;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        #1;
        checks++;
        if (gnt_o !== 4'b0100) begin errors++; $display("FAIL lock_gnt got %b exp 0100", gnt_o); end
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL lock_mreq0 got %b exp 0", mem_req_o); end
        tick();
        req_i = '0;
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o, mem_req_o} !== {4'b0100, 1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL lock_resp got rv=%b err=%b rd=%h mreq=%b exp 0100 1 0 0", rvalid_o, err_o, rdata_o, mem_req_o);
        end
        tick();
        checks++;
        if ({rvalid_o, mem_req_o} !== {4'b0000, 1'b0}) begin
            errors++; $display("FAIL lock_after got rv=%b mreq=%b exp 0000 0", rvalid_o, mem_req_o);
        end
        req_i = 4'b0100; addr_i[2*AWD +: AWD] = 7'd16;
        #1;
        checks++;
        if (gnt_o !== 4'b0100) begin errors++; $display("FAIL unlock_gnt got %b exp 0100", gnt_o); end
        tick();
        req_i = '0;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 7'd16, 32'hA5A5_5A5A}) begin
            errors++; $display("FAIL unlock_mem got req=%b we=%b addr=%0d wd=%h exp 1 1 16 a5a55a5a", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {4'b0100, 1'b0, 32'h0}) begin
            errors++; $display("FAIL unlock_resp got rv=%b err=%b rd=%h exp 0100 0 0", rvalid_o, err_o, rdata_o);
        end
        tick();
        we_i = '0; reglk_ctrl_i = '0;
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        req_i = 4'b0010; we_i = '0; addr_i[1*AWD +: AWD] = 7'd100;
        mem_ready_i = 1'b0; mem_rdata_i = 32'h1234_5678;
        #1;
        checks++;
        if (gnt_o !== 4'b0010) begin errors++; $display("FAIL to_gnt got %b exp 0010", gnt_o); end
        tick();
        req_i = '0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req_o) break;
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL to_mreq_cycles got %0d exp 16", n); end
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {4'b0010, 1'b1, 32'h0}) begin
            errors++; $display("FAIL to_resp got rv=%b err=%b rd=%h exp 0010 1 0", rvalid_o, err_o, rdata_o);
        end
        tick();
        req_i = 4'b0001; addr_i[0*AWD +: AWD] = 7'd9;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
        #1;
        checks++;
        if (gnt_o !== 4'b0001) begin errors++; $display("FAIL to_next_gnt got %b exp 0001", gnt_o); end
        tick();
        req_i = '0;
        tick();
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {4'b0001, 1'b0, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL to_next_resp got rv=%b err=%b rd=%h exp 0001 0 0badf00d", rvalid_o, err_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_collision;
        req_i = 4'b0001; we_i = '0; addr_i[0*AWD +: AWD] = 7'd77;
        mem_ready_i = 1'b0; mem_rdata_i = 32'h5555_AAAA;
        #1;
        checks++;
        if (gnt_o !== 4'b0001) begin errors++; $display("FAIL col_gnt got %b exp 0001", gnt_o); end
        tick();
        req_i = '0;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (mem_req_o !== 1'b1) begin errors++; $display("FAIL col_mreq16 got %b exp 1", mem_req_o); end
        mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        tick();
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {4'b0001, 1'b0, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL col_resp got rv=%b err=%b rd=%h exp 0001 0 cafef00d", rvalid_o, err_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_access;
        req_i = 4'b0100; we_i = '0; addr_i[2*AWD +: AWD] = 7'd50; mem_ready_i = 1'b0;
        #1;
        checks++;
        if (gnt_o !== 4'b0100) begin errors++; $display("FAIL rst_gnt got %b exp 0100", gnt_o); end
        tick();
        req_i = '0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o, mem_req_o, mem_addr_o} !== '0) begin
            errors++; $display("FAIL rst_outputs got rv=%b err=%b rd=%h mreq=%b addr=%0d exp all 0", rvalid_o, err_o, rdata_o, mem_req_o, mem_addr_o);
        end
        req_i = 4'b1111; mem_ready_i = 1'b1; mem_rdata_i = 32'h0000_0042;
        #1;
        checks++;
        if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rst_rrptr got %b exp 0001", gnt_o); end
        tick();
        req_i = '0;
        tick();
        checks++;
        if ({rvalid_o, rdata_o} !== {4'b0001, 32'h42}) begin
            errors++; $display("FAIL rst_next_resp got rv=%b rd=%h exp 0001 42", rvalid_o, rdata_o);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked_write();
        test_timeout();
        test_collision();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_regfile_arbiter.md
Name: dbg_regfile_arbiter

Overview:
Round-robin arbiter sharing the 128x32 debug register file (debug command/status window) among N_REQ requesters: the external register bus, the MOP load path, and others.
Serialises single-word read/write transactions onto one memory-side port.
Enforces region write locks from reglk_ctrl_i.
Bounds each access with a ready timeout.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, word width
AW, 7, word-address width (128 words)
TIMEOUT, 16, max cycles waiting for mem_ready_i before error response

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  N_REQ  per-requester request; held with we/addr/wdata until gnt_o
we_i  in  N_REQ  1=write, 0=read
addr_i  in  N_REQ*AW  word address, requester k at [k*AW +: AW]
wdata_i  in  N_REQ*DATA_WIDTH  write data, packed same way
reglk_ctrl_i  in  8  bit j=1 locks writes to words [16j .. 16j+15]
gnt_o  out  N_REQ  one-hot, 1-cycle acceptance pulse
rvalid_o  out  N_REQ  one-hot, 1-cycle response pulse
err_o  out  1  response error flag, valid with rvalid_o
rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o (reads only)
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  AW  memory word address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data, sampled when mem_ready_i=1
mem_ready_i  in  1  memory completion

Behaviour:
- Reset (rst_i=1 at posedge): state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0, latched fields 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_i, select winner = first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Latch winner index, we, addr and wdata.
  - gnt_o[winner]=1 in that same cycle (combinational from IDLE plus arbitration).
  - Next state:
    - Locked write (we=1 and reglk_ctrl_i[addr[6:4]]=1): RESP with err latched=1; no memory access ever issued.
    - Otherwise: ACCESS.
  - No requests: stay IDLE, outputs 0.
- ACCESS:
  - mem_req_o=1 and mem_we/addr/wdata driven from the latched fields; the counter increments each cycle.
  - mem_ready_i=1: capture mem_rdata_i (reads), err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without mem_ready_i: deassert mem_req_o, err=1, rdata=0, go to RESP.
  - mem_ready_i and timeout in the same cycle: ready wins, err=0.
- RESP:
  - rvalid_o[winner]=1 for exactly 1 cycle, with err_o and rdata_o. rdata_o=0 for writes and errors.
  - rr_ptr <= (winner+1) mod N_REQ, counter cleared, next state IDLE.
- Minimum latencies:
  - Grant to response: 2 cycles with zero-wait memory (ready in the first ACCESS cycle).
  - Back-to-back throughput: 1 transaction per 3 cycles.
- Fairness: a requester holding req_i is granted within N_REQ transactions.
- reglk_ctrl_i is sampled only in IDLE at grant time; changes during ACCESS do not abort an in-flight write.
- req_i dropped by a requester before its grant: simply not selected; no state is held for it.
- Reset mid-ACCESS: return to IDLE next cycle. No rvalid_o is issued for the aborted transaction, and mem_req_o drops immediately.
- Reads are never locked. Address width is exact, so there is no out-of-range case.

Decomposition:
- Shared package dbg_arb_pkg holds:
  - arb_state_e enum (IDLE, ACCESS, RESP)
  - REGION_SHIFT=4 and N_REGIONS=8 constants
  - packed transaction struct {we, addr, wdata}
- One sub-module rr_pick, combinational: inputs req vector and rr_ptr; outputs one-hot grant and winner index.
- Everything else stays in dbg_regfile_arbiter.

Test Plan:
- Single read: req_i=4'b0001, addr=3, memory returns 32'hDEAD_BEEF with zero wait.
  -> gnt_o[0] at cycle 0, mem_req_o at cycle 1, rvalid_o[0] with rdata_o=DEADBEEF and err_o=0 at cycle 2.
- Round robin: all four req_i held for 8 transactions, rr_ptr=0.
  -> grant order 0,1,2,3,0,1,2,3, with no requester granted twice before the others.
- Locked write: reglk_ctrl_i=8'h01, requester 2 writes addr=5.
  -> gnt_o[2], then rvalid_o[2] with err_o=1 the next cycle; mem_req_o never asserts.
  -> The same write to addr=16 reaches memory with err_o=0.
- Timeout: mem_ready_i tied 0, TIMEOUT=16.
  -> mem_req_o high exactly 16 cycles, then rvalid_o with err_o=1 and rdata_o=0.
  -> The next request is served normally.
- Ready/timeout collision: mem_ready_i first asserted in the 16th ACCESS cycle.
  -> err_o=0 and the read data is delivered.
- Reset mid-ACCESS: assert rst_i in the 2nd wait cycle.
  -> No rvalid_o; outputs 0 the next cycle; rr_ptr=0, so requester 0 wins the next arbitration.
